// File: rtl/enc_pkg.sv
// Shared types, widths and helpers for the streaming 8-to-3 encoder.
package enc_pkg;

  localparam int unsigned VEC_W = 8;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned CNT_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_e;

  // Sum of zero-extended bits; CNT_W holds 0..8 without overflow.
  function automatic logic [CNT_W-1:0] popcount(input logic [VEC_W-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < int'(VEC_W); i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/prio_find8.sv
// Combinational priority finder: index of the highest-priority set bit of vec.
module prio_find8
  import enc_pkg::*;
(
  input  logic [VEC_W-1:0] vec,
  input  logic             msb_first,
  output logic [IDX_W-1:0] idx,
  output logic             any_set
);

  // Scan toward the winning end so the last hit seen is the highest priority.
  always_comb begin
    idx     = '0;
    any_set = |vec;
    if (msb_first) begin
      for (int i = 0; i < int'(VEC_W); i++) begin
        if (vec[i]) idx = IDX_W'(i);
      end
    end else begin
      for (int i = int'(VEC_W) - 1; i >= 0; i--) begin
        if (vec[i]) idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/seq_encoder8to3.sv
// Streaming multi-hot to binary encoder: emits one index per handshake in
// priority order, holding a single request vector at a time.
module seq_encoder8to3
  import enc_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [VEC_W-1:0] in_vec,
  output logic             in_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  input  logic             out_ready,
  output logic [CNT_W-1:0] pending,
  output logic             zero_drop
);

  state_e           state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic             out_last_q, out_last_d;
  logic             zero_drop_q, zero_drop_d;

  logic [IDX_W-1:0] nxt_idx;
  logic             nxt_any;

  // Look ahead on the next held vector so every output leaves a flop.
  prio_find8 u_find (
    .vec       (vec_d),
    .msb_first (MSB_FIRST),
    .idx       (nxt_idx),
    .any_set   (nxt_any)
  );

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    pending_d   = pending_q;
    zero_drop_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_vec != '0) begin
            vec_d     = in_vec;
            pending_d = popcount(in_vec);
            state_d   = SERVE;
          end else begin
            zero_drop_d = 1'b1;
          end
        end
      end
      SERVE: begin
        if (out_ready) begin
          vec_d     = vec_q & ~(VEC_W'(1) << out_idx_q);
          pending_d = pending_q - CNT_W'(1);
          if (out_last_q) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    out_valid_d = (state_d == SERVE) && nxt_any;
    out_idx_d   = out_valid_d ? nxt_idx : '0;
    out_last_d  = out_valid_d && (pending_d == CNT_W'(1));
    in_ready_d  = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      vec_q       <= '0;
      pending_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      zero_drop_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      pending_q   <= pending_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      zero_drop_q <= zero_drop_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign pending   = pending_q;
  assign zero_drop = zero_drop_q;

endmodule

// File: tb/tb_seq_encoder8to3.sv
// Bench for seq_encoder8to3: LSB-first and MSB-first instances checked against
// a queue model every cycle, plus directed sequences with literal expectations.
module tb_seq_encoder8to3;

  bit         clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_vec;
  logic       out_ready;

  logic       in_ready0, out_valid0, out_last0, zero_drop0;
  logic [2:0] out_idx0;
  logic [3:0] pending0;
  logic       in_ready1, out_valid1, out_last1, zero_drop1;
  logic [2:0] out_idx1;
  logic [3:0] pending1;

  int checks = 0;
  int fails  = 0;

  int   q0[$];
  int   q1[$];
  logic mz;

  int lg0[$];
  int lg1[$];
  int lp0[$];
  int ll0[$];
  int zcnt;

  seq_encoder8to3 #(.MSB_FIRST(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_vec(in_vec),
    .in_ready(in_ready0), .out_valid(out_valid0), .out_idx(out_idx0),
    .out_last(out_last0), .out_ready(out_ready), .pending(pending0),
    .zero_drop(zero_drop0)
  );

  seq_encoder8to3 #(.MSB_FIRST(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_vec(in_vec),
    .in_ready(in_ready1), .out_valid(out_valid1), .out_idx(out_idx1),
    .out_last(out_last1), .out_ready(out_ready), .pending(pending1),
    .zero_drop(zero_drop1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_seq(input string nm, input int got[$], input int exp[$]);
    chk({nm, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk($sformatf("%s[%0d]", nm, i), got[i], exp[i]);
  endtask

  task automatic clr_logs();
    lg0.delete(); lg1.delete(); lp0.delete(); ll0.delete();
  endtask

  // One cycle of stimulus, applied just after the rising edge.
  task automatic cyc(input logic r, input logic v, input logic [7:0] vec, input logic rdy);
    @(posedge clk);
    #1;
    rst_n     = r;
    in_valid  = v;
    in_vec    = vec;
    out_ready = rdy;
  endtask

  // Model: the list of indices still owed, in emission order for each priority.
  always @(posedge clk) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      mz = 1'b0;
    end else begin
      mz = 1'b0;
      if (q0.size() == 0) begin
        if (in_valid) begin
          if (in_vec == 8'h00) mz = 1'b1;
          else begin
            for (int i = 0; i < 8; i++) begin
              if (in_vec[i]) q0.push_back(i);
              if (in_vec[7-i]) q1.push_back(7 - i);
            end
          end
        end
      end else if (out_ready) begin
        void'(q0.pop_front());
        void'(q1.pop_front());
      end
    end
  end

  // Compare both instances against the model and log handshakes.
  always @(negedge clk) begin
    chk("d0_out_valid", out_valid0, q0.size() != 0);
    chk("d0_out_idx",   out_idx0,   (q0.size() != 0) ? q0[0] : 0);
    chk("d0_out_last",  out_last0,  q0.size() == 1);
    chk("d0_pending",   pending0,   q0.size());
    chk("d0_in_ready",  in_ready0,  q0.size() == 0);
    chk("d0_zero_drop", zero_drop0, mz);
    chk("d1_out_valid", out_valid1, q1.size() != 0);
    chk("d1_out_idx",   out_idx1,   (q1.size() != 0) ? q1[0] : 0);
    chk("d1_out_last",  out_last1,  q1.size() == 1);
    chk("d1_pending",   pending1,   q1.size());
    chk("d1_in_ready",  in_ready1,  q1.size() == 0);
    chk("d1_zero_drop", zero_drop1, mz);
    if (rst_n && out_valid0 && out_ready) begin
      lg0.push_back(int'(out_idx0));
      lp0.push_back(int'(pending0));
      ll0.push_back(int'(out_last0));
    end
    if (rst_n && out_valid1 && out_ready) lg1.push_back(int'(out_idx1));
    if (zero_drop0) zcnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0[$];
    int e1[$];
    int ep[$];
    rst_n = 1'b0; in_valid = 1'b0; in_vec = 8'h00; out_ready = 1'b0; zcnt = 0;

    // Reset held for two edges, then idle.
    cyc(0, 0, 8'h00, 0);
    cyc(0, 0, 8'h00, 0);
    cyc(1, 0, 8'h00, 0);
    @(negedge clk);
    chk("rst_in_ready",  in_ready0,  1);
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_pending",   pending0,   0);
    chk("rst_zero_drop", zero_drop0, 0);

    // Single bit 4.
    clr_logs();
    cyc(1, 1, 8'h10, 1);
    cyc(1, 0, 8'h00, 1);
    cyc(1, 0, 8'h00, 1);
    chk_seq("single_idx",  lg0, '{4});
    chk_seq("single_last", ll0, '{1});
    chk_seq("single_pend", lp0, '{1});
    @(negedge clk);
    chk("single_ready_after", in_ready0, 1);

    // Multi-bit ordering in both priorities.
    clr_logs();
    cyc(1, 1, 8'hA6, 1);
    repeat (5) cyc(1, 0, 8'h00, 1);
    chk_seq("multi_lsb",  lg0, '{1, 2, 5, 7});
    chk_seq("multi_msb",  lg1, '{7, 5, 2, 1});
    chk_seq("multi_pend", lp0, '{4, 3, 2, 1});
    chk_seq("multi_last", ll0, '{0, 0, 0, 1});

    // All bits set under backpressure, in_valid held high throughout.
    clr_logs();
    cyc(1, 1, 8'hFF, 1);
    for (int i = 0; i < 22; i++) cyc(1, 1, 8'hFF, (i % 3) == 0);
    cyc(1, 0, 8'h00, 0);
    cyc(1, 0, 8'h00, 0);
    e0.delete(); e1.delete(); ep.delete();
    for (int i = 0; i < 8; i++) begin
      e0.push_back(i);
      e1.push_back(7 - i);
      ep.push_back(8 - i);
    end
    chk_seq("bp_lsb",  lg0, e0);
    chk_seq("bp_msb",  lg1, e1);
    chk_seq("bp_pend", lp0, ep);

    // All-zero vector is dropped with a single pulse.
    clr_logs();
    zcnt = 0;
    cyc(1, 1, 8'h00, 1);
    cyc(1, 0, 8'h00, 1);
    cyc(1, 0, 8'h00, 1);
    chk("zero_pulses", zcnt, 1);
    chk("zero_no_out", lg0.size(), 0);

    // Reset in the middle of serving 8'h0F.
    clr_logs();
    cyc(1, 1, 8'h0F, 1);
    cyc(1, 0, 8'h00, 1);
    cyc(0, 0, 8'h00, 1);
    cyc(1, 0, 8'h00, 1);
    @(negedge clk);
    chk("midrst_out_valid", out_valid0, 0);
    chk("midrst_pending",   pending0,   0);
    chk("midrst_in_ready",  in_ready0,  1);
    repeat (3) cyc(1, 0, 8'h00, 1);
    chk_seq("midrst_lsb", lg0, '{0});
    chk_seq("midrst_msb", lg1, '{3});

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
